// File: rtl/uart_stream_pkg.sv
// Shared encodings for the byte streamer that feeds uart_tx.
package uart_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3
    } state_t;

    // Which header byte, if any, is currently loaded on the transmitter.
    typedef enum logic [1:0] {
        HDR_NONE = 2'd0,
        HDR_IDX0 = 2'd1,
        HDR_IDX1 = 2'd2
    } hdr_idx_t;

    localparam logic [7:0] HDR_BYTE0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR_BYTE1_DEFAULT = 8'h55;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered status flags and a sticky overflow bit.
module sync_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Byte,
    input  logic              i_Rd_En,
    output logic [7:0]        o_Rd_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              push;
    logic              pop;

    // Full is the registered flag, so a write while full is dropped even if a pop happens.
    assign push      = i_Wr_En && !o_Full;
    assign pop       = i_Rd_En && !o_Empty;
    assign o_Rd_Byte = mem[rd_ptr];

    always_comb begin
        count_next = o_Count;
        case ({push, pop})
            2'b10:   count_next = o_Count + (ADDR_W+1)'(1);
            2'b01:   count_next = o_Count - (ADDR_W+1)'(1);
            default: count_next = o_Count;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            o_Count <= count_next;
            o_Full  <= (count_next == DEPTH_CNT);
            o_Empty <= (count_next == '0);
            if (i_Wr_En && o_Full) begin
                o_Overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_byte_streamer.sv
// Drains a byte FIFO into uart_tx one byte at a time, optionally prefixing a two-byte sync header.
//   state       | meaning
//   S_IDLE      | wait for a free transmitter and a pending header or queued byte
//   S_LAUNCH    | o_Tx_DV pulse for the loaded byte
//   S_WAIT_DONE | wait for i_Tx_Done to rise
//   S_GAP       | wait for i_Tx_Done to fall; chain HDR_BYTE1 after HDR_BYTE0
module uart_tx_byte_streamer
    import uart_stream_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] HDR_BYTE0 = HDR_BYTE0_DEFAULT,
    parameter logic [7:0] HDR_BYTE1 = HDR_BYTE1_DEFAULT
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    input  logic              i_Frame_Start,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy
);

    state_t     state;
    state_t     state_next;
    hdr_idx_t   hdr_idx;
    hdr_idx_t   hdr_idx_next;
    logic       hdr_pend;
    logic       hdr_clr;
    logic [7:0] tx_byte_next;
    logic       fifo_pop;
    logic [7:0] fifo_byte;
    logic       tx_free;

    sync_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Wr_En    (i_Wr_En),
        .i_Wr_Byte  (i_Wr_Byte),
        .i_Rd_En    (fifo_pop),
        .o_Rd_Byte  (fifo_byte),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Count    (o_Count),
        .o_Overflow (o_Overflow)
    );

    // uart_tx is not reset with us, so a frame may still be finishing after our reset.
    assign tx_free = !i_Tx_Active && !i_Tx_Done;
    assign o_Busy  = (state != S_IDLE);

    always_comb begin
        state_next   = state;
        hdr_idx_next = hdr_idx;
        tx_byte_next = o_Tx_Byte;
        fifo_pop     = 1'b0;
        hdr_clr      = 1'b0;
        o_Tx_DV      = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_free && hdr_pend) begin
                    tx_byte_next = HDR_BYTE0;
                    hdr_idx_next = HDR_IDX0;
                    state_next   = S_LAUNCH;
                end else if (tx_free && !o_Empty) begin
                    fifo_pop     = 1'b1;
                    tx_byte_next = fifo_byte;
                    hdr_idx_next = HDR_NONE;
                    state_next   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                o_Tx_DV    = 1'b1;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (!i_Tx_Done) begin
                    if (hdr_idx == HDR_IDX0) begin
                        tx_byte_next = HDR_BYTE1;
                        hdr_idx_next = HDR_IDX1;
                        hdr_clr      = 1'b1;
                        state_next   = S_LAUNCH;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            hdr_idx   <= HDR_NONE;
            hdr_pend  <= 1'b0;
            o_Tx_Byte <= 8'h00;
        end else begin
            state     <= state_next;
            hdr_idx   <= hdr_idx_next;
            // A new request in the clearing cycle wins and queues another header.
            hdr_pend  <= i_Frame_Start || (hdr_pend && !hdr_clr);
            o_Tx_Byte <= tx_byte_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_byte_streamer.sv
// Bench for uart_tx_byte_streamer driving a behavioural uart_tx (CLKS_PER_BIT=4) and a line receiver.
module tb_uart_tx_byte_streamer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_byte;
        logic       frame_start;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
        logic       exp_sent;
    } vec_t;

    logic            clk = 1'b0;
    logic            i_Reset = 1'b1;
    logic            i_Wr_En = 1'b0;
    logic [7:0]      i_Wr_Byte = 8'h00;
    logic            i_Frame_Start = 1'b0;
    logic            o_Full;
    logic            o_Empty;
    logic [ADDR_W:0] o_Count;
    logic            o_Overflow;
    logic            o_Tx_DV;
    logic [7:0]      o_Tx_Byte;
    logic            o_Busy;
    logic            tx_active;
    logic            tx_done;
    logic            stall = 1'b0;

    // behavioural uart_tx, no reset
    logic [2:0]      m_st = 3'd0;
    logic [1:0]      m_cnt = 2'd0;
    logic [2:0]      m_bit = 3'd0;
    logic [7:0]      m_data = 8'h00;
    logic            m_line = 1'b1;
    logic            m_active = 1'b0;
    logic            m_done = 1'b0;

    int              vec_cnt = 0;
    int              miss_cnt = 0;
    int              dv_cnt = 0;
    int              rx_cnt = 0;
    int              push_cnt = 0;
    logic            dv_prev = 1'b0;
    logic [7:0]      exp_q[$];
    vec_t            vecs[18];

    assign tx_active = m_active | stall;
    assign tx_done   = m_done & ~stall;

    uart_tx_byte_streamer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (i_Reset),
        .i_Wr_En       (i_Wr_En),
        .i_Wr_Byte     (i_Wr_Byte),
        .o_Full        (o_Full),
        .o_Empty       (o_Empty),
        .o_Count       (o_Count),
        .o_Overflow    (o_Overflow),
        .i_Frame_Start (i_Frame_Start),
        .o_Tx_DV       (o_Tx_DV),
        .o_Tx_Byte     (o_Tx_Byte),
        .i_Tx_Active   (tx_active),
        .i_Tx_Done     (tx_done),
        .o_Busy        (o_Busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        case (m_st)
            3'd0: begin
                m_line <= 1'b1;
                m_done <= 1'b0;
                m_cnt  <= 2'd0;
                m_bit  <= 3'd0;
                if (o_Tx_DV) begin
                    m_active <= 1'b1;
                    m_data   <= o_Tx_Byte;
                    m_st     <= 3'd1;
                end
            end
            3'd1: begin
                m_line <= 1'b0;
                m_cnt  <= m_cnt + 2'd1;
                if (m_cnt == 2'd3) m_st <= 3'd2;
            end
            3'd2: begin
                m_line <= m_data[m_bit];
                m_cnt  <= m_cnt + 2'd1;
                if (m_cnt == 2'd3) begin
                    m_bit <= m_bit + 3'd1;
                    if (m_bit == 3'd7) m_st <= 3'd3;
                end
            end
            3'd3: begin
                m_line <= 1'b1;
                m_cnt  <= m_cnt + 2'd1;
                if (m_cnt == 2'd3) begin
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                    m_st     <= 3'd4;
                end
            end
            default: begin
                m_done <= 1'b1;
                m_st   <= 3'd0;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit sent);
        i_Wr_En   = 1'b1;
        i_Wr_Byte = b;
        if (sent) begin
            exp_q.push_back(b);
            push_cnt++;
        end
        tick();
        i_Wr_En = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(o_Busy == 1'b0 && o_Empty == 1'b1 && m_st == 3'd0 && m_done == 1'b0) && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({name, "_in_time"}, 32'(n < budget), 32'd1);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Line receiver: samples mid-bit on the falling clock edge.
    initial begin
        logic [7:0] rx_b;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (m_line == 1'b0) begin
                @(negedge clk);
                chk("rx_start_bit", 32'(m_line), 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (4) @(negedge clk);
                    rx_b[b] = m_line;
                end
                repeat (4) @(negedge clk);
                chk("rx_stop_bit", 32'(m_line), 32'd1);
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL rx_unexpected: got %02h, expected no byte", rx_b);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("rx_byte", 32'(rx_b), 32'(exp_b));
                end
            end
        end
    end

    // Every DV must be a single-cycle pulse into an idle transmitter.
    always @(negedge clk) begin
        if (o_Tx_DV) begin
            dv_cnt++;
            chk("dv_into_free_tx", 32'({tx_active, tx_done}), 32'd0);
            chk("dv_single_cycle", 32'(dv_prev), 32'd0);
        end
        dv_prev = o_Tx_DV;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        tick();
        tick();
        chk("rst_dv", 32'(o_Tx_DV), 32'd0);
        chk("rst_byte", 32'(o_Tx_Byte), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_ovf", 32'(o_Overflow), 32'd0);
        chk("rst_empty", 32'(o_Empty), 32'd1);
        chk("rst_full", 32'(o_Full), 32'd0);
        chk("rst_count", 32'(o_Count), 32'd0);
        i_Reset = 1'b0;
        tick();

        // single byte, cycle-exact launch
        write_byte(8'h3C, 1'b1);
        chk("single_c1_dv", 32'(o_Tx_DV), 32'd0);
        chk("single_c1_empty", 32'(o_Empty), 32'd0);
        chk("single_c1_count", 32'(o_Count), 32'd1);
        tick();
        chk("single_c2_dv", 32'(o_Tx_DV), 32'd1);
        chk("single_c2_byte", 32'(o_Tx_Byte), 32'h3C);
        chk("single_c2_empty", 32'(o_Empty), 32'd1);
        tick();
        chk("single_c3_dv", 32'(o_Tx_DV), 32'd0);
        n = 0;
        while (o_Busy && n < 200) begin
            tick();
            n++;
        end
        chk("single_busy_falls", 32'(o_Busy), 32'd0);
        chk("single_done_low_at_idle", 32'(tx_done), 32'd0);
        wait_drain("single", 300);

        // burst order
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        wait_drain("burst", 1000);

        // header, plus a second request while AA is in flight
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        push_cnt += 2;
        i_Frame_Start = 1'b1;
        tick();
        i_Frame_Start = 1'b0;
        write_byte(8'h10, 1'b1);
        write_byte(8'h20, 1'b1);
        n = 0;
        while (!m_active && n < 50) begin
            tick();
            n++;
        end
        chk("hdr_aa_in_flight", 32'(m_data), 32'hAA);
        i_Frame_Start = 1'b1;
        tick();
        i_Frame_Start = 1'b0;
        wait_drain("header", 1000);

        // pointer wrap across two batches
        for (int i = 0; i < 12; i++) write_byte(8'(8'h40 + i), 1'b1);
        wait_drain("wrap_a", 2000);
        for (int i = 0; i < 12; i++) write_byte(8'(8'h60 + i), 1'b1);
        wait_drain("wrap_b", 2000);

        // overflow with the transmitter stalled
        stall = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            vecs[i].wr_en       = 1'b1;
            vecs[i].wr_byte     = 8'(8'h80 + i);
            vecs[i].frame_start = 1'b0;
            vecs[i].exp_count   = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].exp_full    = (i >= 15);
            vecs[i].exp_empty   = 1'b0;
            vecs[i].exp_ovf     = (i >= 16);
            vecs[i].exp_sent    = (i < 16);
        end
        vecs[17] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 18; i++) begin
            i_Wr_En       = vecs[i].wr_en;
            i_Wr_Byte     = vecs[i].wr_byte;
            i_Frame_Start = vecs[i].frame_start;
            if (vecs[i].exp_sent) begin
                exp_q.push_back(vecs[i].wr_byte);
                push_cnt++;
            end
            tick();
            chk($sformatf("ovf_v%0d_count", i), 32'(o_Count), 32'(vecs[i].exp_count));
            chk($sformatf("ovf_v%0d_full", i), 32'(o_Full), 32'(vecs[i].exp_full));
            chk($sformatf("ovf_v%0d_empty", i), 32'(o_Empty), 32'(vecs[i].exp_empty));
            chk($sformatf("ovf_v%0d_ovf", i), 32'(o_Overflow), 32'(vecs[i].exp_ovf));
        end
        i_Wr_En = 1'b0;
        stall = 1'b0;
        wait_drain("ovf_drain", 3000);

        // reset while a data byte is on the line
        write_byte(8'h77, 1'b1);
        n = 0;
        while (m_st != 3'd2 && n < 50) begin
            tick();
            n++;
        end
        chk("rstmid_in_data_bits", 32'(m_st), 32'd2);
        for (int i = 0; i < 17; i++) write_byte(8'(8'hE0 + i), 1'b0);
        tick();
        chk("rstmid_pre_full", 32'(o_Full), 32'd1);
        chk("rstmid_pre_ovf", 32'(o_Overflow), 32'd1);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("rstmid_empty", 32'(o_Empty), 32'd1);
        chk("rstmid_count", 32'(o_Count), 32'd0);
        chk("rstmid_ovf", 32'(o_Overflow), 32'd0);
        chk("rstmid_busy", 32'(o_Busy), 32'd0);
        write_byte(8'h99, 1'b1);
        n = 0;
        while (!o_Tx_DV && n < 200) begin
            tick();
            n++;
        end
        chk("rstmid_next_dv", 32'(o_Tx_DV), 32'd1);
        chk("rstmid_next_byte", 32'(o_Tx_Byte), 32'h99);
        chk("rstmid_prev_frame_done", 32'({m_active, m_done}), 32'd0);
        wait_drain("rstmid", 500);

        chk("total_rx_frames", 32'(rx_cnt), 32'(push_cnt));
        chk("total_dv_pulses", 32'(dv_cnt), 32'(push_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
